red_pitaya_daisy_tx_framer: RTL and testbench

Packetizer directly upstream of the daisy-chain TX serializer. Buffers 16-bit user words in a small synchronous FIFO and emits framed packets: one header word, then 1..MAX_LEN payload words. Packets go out through the serializer's one-word-in-four ready/valid slot. Also provides a training mode that streams a fixed pattern for link alignment, plus packet and overflow status.

---
 rtl/red_pitaya_daisy_pkg.sv | 28 ++
 rtl/red_pitaya_daisy_fifo.sv | 80 ++++++++
 rtl/red_pitaya_daisy_tx_framer.sv | 213 +++++++++++++++++++++
 tb/tb_red_pitaya_daisy_tx_framer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_daisy_pkg.sv
// ---------------------------------------------------------------------------
// red_pitaya_daisy_pkg
//
// Shared definitions for the daisy-chain TX framer:
//   - header word layout: {sync byte, payload length}
//   - framer state encoding
//   - helper that assembles a header word from a length
// ---------------------------------------------------------------------------
package red_pitaya_daisy_pkg;

    localparam int HDR_SYNC_W = 8;
    localparam int HDR_LEN_W  = 8;
    localparam int WORD_W     = HDR_SYNC_W + HDR_LEN_W;

    localparam logic [HDR_SYNC_W-1:0] HDR_SYNC = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_PAY   = 2'd2,
        ST_TRAIN = 2'd3
    } framer_state_e;

    function automatic logic [WORD_W-1:0] make_header(input logic [HDR_LEN_W-1:0] len);
        return {HDR_SYNC, len};
    endfunction

endpackage

// File: rtl/red_pitaya_daisy_fifo.sv
// ---------------------------------------------------------------------------
// red_pitaya_daisy_fifo
//
// Generic synchronous FIFO, 2**AW entries of DW bits, first-word-fall-through:
// head_o always shows the oldest stored word while the FIFO is not empty.
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset (empties the FIFO)
//   wr_en_i   write request; ignored while full
//   wr_dat_i  write data
//   rd_en_i   pop request; ignored while empty
//   head_o    oldest word (valid when !empty_o)
//   full_o    no free entry
//   empty_o   no stored entry
//   count_o   number of stored entries (0 .. 2**AW)
// ---------------------------------------------------------------------------
module red_pitaya_daisy_fifo #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_dat_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    // Pointers wrap naturally at 2**AW; the separate count removes the
    // usual full/empty ambiguity of equal pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/red_pitaya_daisy_tx_framer.sv
// ---------------------------------------------------------------------------
// red_pitaya_daisy_tx_framer
//
// Packetizer in front of the daisy-chain TX serializer. User words are
// buffered in a FIFO and sent as packets {A5,len} + len payload words
// through the serializer's ready/valid slot. A training mode streams a fixed
// pattern for link alignment.
//
// Ports:
//   par_clk_i        parallel clock (shared with the serializer)
//   par_rst_i        synchronous active-high reset
//   cfg_en_i         allows new packets to start
//   cfg_train_i      training mode request
//   cfg_train_pat_i  training word
//   stat_clr_i       clears stat_pkt_o / stat_ovf_o
//   usr_dv_i         user word valid
//   usr_dat_i        user word
//   usr_rdy_o        FIFO not full
//   tx_rdy_i         serializer slot ready
//   tx_dv_o          word valid to serializer (registered)
//   tx_dat_o         word to serializer (registered)
//   stat_pkt_o       completed packet counter (wraps)
//   stat_ovf_o       sticky: a user word was dropped
// ---------------------------------------------------------------------------
module red_pitaya_daisy_tx_framer
    import red_pitaya_daisy_pkg::*;
#(
    parameter int FIFO_AW = 4,
    parameter int MAX_LEN = 8,
    parameter int TMO     = 64
) (
    input  logic        par_clk_i,
    input  logic        par_rst_i,
    input  logic        cfg_en_i,
    input  logic        cfg_train_i,
    input  logic [15:0] cfg_train_pat_i,
    input  logic        stat_clr_i,
    input  logic        usr_dv_i,
    input  logic [15:0] usr_dat_i,
    output logic        usr_rdy_o,
    input  logic        tx_rdy_i,
    output logic        tx_dv_o,
    output logic [15:0] tx_dat_o,
    output logic [31:0] stat_pkt_o,
    output logic        stat_ovf_o
);

    localparam int                 CW       = FIFO_AW + 1;
    localparam int                 TW       = $clog2(TMO);
    localparam logic [CW-1:0]      MAX_CNT  = CW'(MAX_LEN);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TMO - 1);

    framer_state_e          state_q, state_d;
    logic                   tx_dv_q, tx_dv_d;
    logic [15:0]            tx_dat_q, tx_dat_d;
    logic [HDR_LEN_W-1:0]   len_q, len_d;
    logic [HDR_LEN_W-1:0]   rem_q, rem_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [31:0]            stat_pkt_q, stat_pkt_d;
    logic                   stat_ovf_q, stat_ovf_d;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [15:0]            fifo_head;
    logic                   fifo_pop;
    logic                   xfer;
    logic                   start_ok;
    logic                   pkt_done;

    red_pitaya_daisy_fifo #(
        .AW (FIFO_AW),
        .DW (16)
    ) u_fifo (
        .clk_i    (par_clk_i),
        .rst_i    (par_rst_i),
        .wr_en_i  (usr_dv_i),
        .wr_dat_i (usr_dat_i),
        .rd_en_i  (fifo_pop),
        .head_o   (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign xfer     = tx_dv_q && tx_rdy_i;
    assign start_ok = cfg_en_i && !fifo_empty &&
                      ((fifo_count >= MAX_CNT) || (tmo_q == TMO_LAST));

    // Next-state logic. The outgoing word is registered: whenever the
    // current word transfers, the following word is loaded on the same edge,
    // so it is ready long before the serializer's next slot.
    always_comb begin
        state_d  = state_q;
        tx_dv_d  = tx_dv_q;
        tx_dat_d = tx_dat_q;
        len_d    = len_q;
        rem_d    = rem_q;
        tmo_d    = tmo_q;
        fifo_pop = 1'b0;
        pkt_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The timeout counter saturates at TMO-1 so that a short
                // packet held back by cfg_en_i=0 leaves as soon as it returns.
                if (fifo_empty) begin
                    tmo_d = '0;
                end else if (tmo_q != TMO_LAST) begin
                    tmo_d = tmo_q + 1'b1;
                end

                if (cfg_train_i) begin
                    state_d  = ST_TRAIN;
                    tx_dv_d  = 1'b1;
                    tx_dat_d = cfg_train_pat_i;
                end else if (start_ok) begin
                    len_d    = (fifo_count >= MAX_CNT) ? HDR_LEN_W'(MAX_LEN)
                                                       : HDR_LEN_W'(fifo_count);
                    tx_dat_d = make_header(len_d);
                    tx_dv_d  = 1'b1;
                    tmo_d    = '0;
                    state_d  = ST_HDR;
                end
            end

            ST_HDR: begin
                if (xfer) begin
                    fifo_pop = 1'b1;
                    tx_dat_d = fifo_head;
                    rem_d    = len_q;
                    state_d  = ST_PAY;
                end
            end

            // rem_q counts payload words still to go, including the one on
            // the output now; the FIFO is guaranteed to hold them.
            ST_PAY: begin
                if (xfer) begin
                    if (rem_q > 8'd1) begin
                        rem_d    = rem_q - 1'b1;
                        fifo_pop = 1'b1;
                        tx_dat_d = fifo_head;
                    end else begin
                        tx_dv_d  = 1'b0;
                        pkt_done = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end

            ST_TRAIN: begin
                if (cfg_train_i) begin
                    tx_dat_d = cfg_train_pat_i;
                end else begin
                    tx_dv_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tx_dv_d = 1'b0;
            end
        endcase
    end

    // Status: a clear in the same cycle as an event wins.
    always_comb begin
        stat_pkt_d = stat_pkt_q;
        stat_ovf_d = stat_ovf_q;
        if (stat_clr_i) begin
            stat_pkt_d = '0;
            stat_ovf_d = 1'b0;
        end else begin
            if (pkt_done) begin
                stat_pkt_d = stat_pkt_q + 32'd1;
            end
            if (usr_dv_i && fifo_full) begin
                stat_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge par_clk_i) begin
        if (par_rst_i) begin
            state_q    <= ST_IDLE;
            tx_dv_q    <= 1'b0;
            tx_dat_q   <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            tmo_q      <= '0;
            stat_pkt_q <= '0;
            stat_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_dv_q    <= tx_dv_d;
            tx_dat_q   <= tx_dat_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            stat_pkt_q <= stat_pkt_d;
            stat_ovf_q <= stat_ovf_d;
        end
    end

    assign usr_rdy_o  = !fifo_full;
    assign tx_dv_o    = tx_dv_q;
    assign tx_dat_o   = tx_dat_q;
    assign stat_pkt_o = stat_pkt_q;
    assign stat_ovf_o = stat_ovf_q;

endmodule

// File: tb/tb_red_pitaya_daisy_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_red_pitaya_daisy_tx_framer
//
// Drives directed scenarios followed by a randomized phase. A packet-level
// reference model (queue of buffered words plus the words still owed to the
// current packet) predicts every output each cycle; directed scenarios add
// literal expectations on the transferred word stream.
// ---------------------------------------------------------------------------
module tb_red_pitaya_daisy_tx_framer;

    localparam int FIFO_AW = 4;
    localparam int MAX_LEN = 8;
    localparam int TMO     = 64;
    localparam int DEPTH   = 1 << FIFO_AW;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_PKT   = 1;
    localparam int MODE_TRAIN = 2;

    logic        par_clk_i       = 1'b0;
    logic        par_rst_i       = 1'b1;
    logic        cfg_en_i        = 1'b0;
    logic        cfg_train_i     = 1'b0;
    logic [15:0] cfg_train_pat_i = '0;
    logic        stat_clr_i      = 1'b0;
    logic        usr_dv_i        = 1'b0;
    logic [15:0] usr_dat_i       = '0;
    logic        usr_rdy_o;
    logic        tx_rdy_i        = 1'b0;
    logic        tx_dv_o;
    logic [15:0] tx_dat_o;
    logic [31:0] stat_pkt_o;
    logic        stat_ovf_o;

    always #5 par_clk_i = ~par_clk_i;

    red_pitaya_daisy_tx_framer #(
        .FIFO_AW (FIFO_AW),
        .MAX_LEN (MAX_LEN),
        .TMO     (TMO)
    ) dut (
        .par_clk_i       (par_clk_i),
        .par_rst_i       (par_rst_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_train_i     (cfg_train_i),
        .cfg_train_pat_i (cfg_train_pat_i),
        .stat_clr_i      (stat_clr_i),
        .usr_dv_i        (usr_dv_i),
        .usr_dat_i       (usr_dat_i),
        .usr_rdy_o       (usr_rdy_o),
        .tx_rdy_i        (tx_rdy_i),
        .tx_dv_o         (tx_dv_o),
        .tx_dat_o        (tx_dat_o),
        .stat_pkt_o      (stat_pkt_o),
        .stat_ovf_o      (stat_ovf_o)
    );

    int          nChecks = 0;
    int          nFails  = 0;
    int          cyc     = 0;
    bit          slotEn  = 1'b0;
    int          slotPh  = 0;
    logic [15:0] logQ[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge par_clk_i);
            #1;
        end
    endtask

    // One user word, held for exactly one clock edge.
    task automatic applyStimulus(input logic [15:0] w);
        usr_dv_i  = 1'b1;
        usr_dat_i = w;
        tick(1);
        usr_dv_i  = 1'b0;
    endtask

    task automatic waitXfers(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (logQ.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checkOutput(name, logQ.size() >= n, 1'b1);
    endtask

    task automatic checkWord(input string name, input int idx, input logic [15:0] exp);
        logic [31:0] act;
        act = (idx < logQ.size()) ? {16'h0000, logQ[idx]} : 32'hFFFF_FFFF;
        checkOutput(name, act, {16'h0000, exp});
    endtask

    task automatic pulseClear();
        stat_clr_i = 1'b1;
        tick(1);
        stat_clr_i = 1'b0;
    endtask

    // The serializer slot: one ready cycle in every four.
    initial begin
        forever begin
            @(posedge par_clk_i);
            #1;
            slotPh   = (slotPh + 1) % 4;
            tx_rdy_i = slotEn && (slotPh == 0);
        end
    end

    always @(posedge par_clk_i) cyc <= cyc + 1;

    // Reference model: buffered words in a queue; a packet is the header
    // followed by the words it still owes, taken from the queue one per
    // transfer.
    logic [15:0] mq[$];
    int          mMode   = MODE_IDLE;
    bit          mDv     = 1'b0;
    logic [15:0] mDat    = '0;
    int          mToPop  = 0;
    int          mWait   = 0;
    logic [31:0] mPkts   = '0;
    bit          mOvf    = 1'b0;
    int          mN;
    int          mLen;
    int          mPrevMode;
    bit          mDone;
    bit          mStart;

    always @(posedge par_clk_i) begin
        if (par_rst_i) begin
            mq.delete();
            mMode  = MODE_IDLE;
            mDv    = 1'b0;
            mDat   = '0;
            mToPop = 0;
            mWait  = 0;
            mPkts  = '0;
            mOvf   = 1'b0;
        end else begin
            mN        = mq.size();
            mPrevMode = mMode;
            mDone     = 1'b0;
            mStart    = 1'b0;
            if (mMode == MODE_IDLE) begin
                if (cfg_train_i) begin
                    mMode = MODE_TRAIN;
                    mDv   = 1'b1;
                    mDat  = cfg_train_pat_i;
                end else if (cfg_en_i && mN > 0 && (mN >= MAX_LEN || mWait == TMO - 1)) begin
                    mLen   = (mN < MAX_LEN) ? mN : MAX_LEN;
                    mMode  = MODE_PKT;
                    mDv    = 1'b1;
                    mDat   = {8'hA5, 8'(mLen)};
                    mToPop = mLen;
                    mStart = 1'b1;
                end
            end else if (mMode == MODE_PKT) begin
                if (mDv && tx_rdy_i) begin
                    if (mToPop > 0) begin
                        mDat = mq.pop_front();
                        mToPop--;
                    end else begin
                        mDv   = 1'b0;
                        mMode = MODE_IDLE;
                        mDone = 1'b1;
                    end
                end
            end else begin
                if (cfg_train_i) begin
                    mDat = cfg_train_pat_i;
                end else begin
                    mDv   = 1'b0;
                    mMode = MODE_IDLE;
                end
            end
            if (mPrevMode == MODE_IDLE) begin
                if (mStart || mN == 0) begin
                    mWait = 0;
                end else if (mWait < TMO - 1) begin
                    mWait++;
                end
            end
            if (usr_dv_i && mN < DEPTH) begin
                mq.push_back(usr_dat_i);
            end
            if (stat_clr_i) begin
                mPkts = '0;
                mOvf  = 1'b0;
            end else begin
                if (mDone) mPkts = mPkts + 32'd1;
                if (usr_dv_i && mN >= DEPTH) mOvf = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of transfers for
    // the directed literal checks.
    always @(negedge par_clk_i) begin
        checkOutput("tx_dv", tx_dv_o, mDv);
        if (mDv) begin
            checkOutput("tx_dat", tx_dat_o, mDat);
        end
        checkOutput("usr_rdy", usr_rdy_o, mq.size() < DEPTH);
        checkOutput("stat_pkt", stat_pkt_o, mPkts);
        checkOutput("stat_ovf", stat_ovf_o, mOvf);
        if (!par_rst_i && tx_dv_o && tx_rdy_i) begin
            logQ.push_back(tx_dat_o);
        end
    end

    int landCyc;
    int hdrCyc;
    int rate;
    int k;

    initial begin
        // Reset and quiet idle.
        tick(3);
        checkOutput("rst_tx_dv", tx_dv_o, 1'b0);
        checkOutput("rst_tx_dat", tx_dat_o, 32'h0);
        checkOutput("rst_usr_rdy", usr_rdy_o, 1'b1);
        checkOutput("rst_stat_pkt", stat_pkt_o, 32'h0);
        checkOutput("rst_stat_ovf", stat_ovf_o, 1'b0);
        par_rst_i = 1'b0;
        tick(100);
        checkOutput("idle_tx_dv", tx_dv_o, 1'b0);
        checkOutput("idle_usr_rdy", usr_rdy_o, 1'b1);
        checkOutput("idle_stat_pkt", stat_pkt_o, 32'h0);

        // Full packet of eight words.
        $display("[TB] full packet");
        slotEn   = 1'b1;
        cfg_en_i = 1'b1;
        logQ.delete();
        for (int i = 0; i < 8; i++) applyStimulus(16'h1000 + 16'(i));
        waitXfers(9, 200, "t2_xfer_timeout");
        checkWord("t2_hdr", 0, 16'hA508);
        for (int i = 0; i < 8; i++) checkWord("t2_pay", i + 1, 16'h1000 + 16'(i));
        tick(2);
        checkOutput("t2_stat_pkt", stat_pkt_o, 32'd1);

        // Short packet forced by the timeout.
        $display("[TB] timeout packet");
        logQ.delete();
        applyStimulus(16'h2000);
        landCyc = cyc;
        applyStimulus(16'h2001);
        applyStimulus(16'h2002);
        k = 0;
        while (!tx_dv_o && k < 200) begin
            tick(1);
            k++;
        end
        hdrCyc = cyc;
        checkOutput("t3_hdr_delay", hdrCyc - landCyc, TMO);
        checkOutput("t3_hdr_word", tx_dat_o, 32'h0000_A503);
        waitXfers(4, 100, "t3_xfer_timeout");
        checkWord("t3_hdr", 0, 16'hA503);
        for (int i = 0; i < 3; i++) checkWord("t3_pay", i + 1, 16'h2000 + 16'(i));
        tick(2);
        checkOutput("t3_stat_pkt", stat_pkt_o, 32'd2);

        // Overflow with packets held off, then release.
        $display("[TB] overflow");
        pulseClear();
        checkOutput("t4_clr_pkt", stat_pkt_o, 32'h0);
        cfg_en_i = 1'b0;
        logQ.delete();
        for (int i = 0; i < 16; i++) applyStimulus(16'h4000 + 16'(i));
        checkOutput("t4_full_rdy", usr_rdy_o, 1'b0);
        checkOutput("t4_no_ovf_yet", stat_ovf_o, 1'b0);
        applyStimulus(16'h4010);
        checkOutput("t4_ovf", stat_ovf_o, 1'b1);
        tick(5);
        checkOutput("t4_held_dv", tx_dv_o, 1'b0);
        cfg_en_i = 1'b1;
        waitXfers(18, 400, "t4_xfer_timeout");
        for (int p = 0; p < 2; p++) begin
            checkWord("t4_hdr", p * 9, 16'hA508);
            for (int i = 0; i < 8; i++) checkWord("t4_pay", p * 9 + i + 1, 16'h4000 + 16'(p * 8 + i));
        end
        tick(2);
        checkOutput("t4_stat_pkt", stat_pkt_o, 32'd2);
        checkOutput("t4_ovf_sticky", stat_ovf_o, 1'b1);
        pulseClear();
        checkOutput("t4_clr_pkt2", stat_pkt_o, 32'h0);
        checkOutput("t4_clr_ovf", stat_ovf_o, 1'b0);

        // Training requested mid-packet.
        $display("[TB] training");
        cfg_train_pat_i = 16'hF0F0;
        logQ.delete();
        for (int i = 0; i < 8; i++) applyStimulus(16'h5000 + 16'(i));
        waitXfers(3, 200, "t5_pay_timeout");
        cfg_train_i = 1'b1;
        waitXfers(17, 300, "t5_train_timeout");
        checkWord("t5_hdr", 0, 16'hA508);
        for (int i = 0; i < 8; i++) checkWord("t5_pay", i + 1, 16'h5000 + 16'(i));
        for (int i = 9; i < 17; i++) checkWord("t5_train", i, 16'hF0F0);
        cfg_train_i = 1'b0;
        tick(1);
        checkOutput("t5_train_off_dv", tx_dv_o, 1'b0);
        tick(4);

        // Reset in the middle of a packet.
        $display("[TB] reset mid-packet");
        pulseClear();
        logQ.delete();
        for (int i = 0; i < 8; i++) applyStimulus(16'h6000 + 16'(i));
        waitXfers(4, 200, "t6_pay_timeout");
        par_rst_i = 1'b1;
        tick(1);
        checkOutput("t6_rst_dv", tx_dv_o, 1'b0);
        checkOutput("t6_rst_rdy", usr_rdy_o, 1'b1);
        checkOutput("t6_rst_pkt", stat_pkt_o, 32'h0);
        par_rst_i = 1'b0;
        logQ.delete();
        for (int i = 0; i < 8; i++) applyStimulus(16'h7000 + 16'(i));
        waitXfers(9, 200, "t6_xfer_timeout");
        checkWord("t6_hdr", 0, 16'hA508);
        for (int i = 0; i < 8; i++) checkWord("t6_pay", i + 1, 16'h7000 + 16'(i));

        // Randomized traffic against the model.
        $display("[TB] random traffic");
        for (int blk = 0; blk < 6; blk++) begin
            case (blk % 3)
                0:       rate = 10;
                1:       rate = 40;
                default: rate = 90;
            endcase
            for (int c = 0; c < 500; c++) begin
                usr_dv_i        = ($urandom_range(0, 99) < rate);
                usr_dat_i       = 16'($urandom);
                cfg_train_pat_i = 16'($urandom);
                if (cfg_en_i) begin
                    if ($urandom_range(0, 199) == 0) cfg_en_i = 1'b0;
                end else begin
                    if ($urandom_range(0, 19) == 0) cfg_en_i = 1'b1;
                end
                if (cfg_train_i) begin
                    if ($urandom_range(0, 19) == 0) cfg_train_i = 1'b0;
                end else begin
                    if ($urandom_range(0, 399) == 0) cfg_train_i = 1'b1;
                end
                stat_clr_i = ($urandom_range(0, 99) == 0);
                par_rst_i  = ($urandom_range(0, 499) == 0);
                slotEn     = ($urandom_range(0, 19) != 0);
                tick(1);
            end
        end

        // Drain whatever is left.
        usr_dv_i    = 1'b0;
        cfg_train_i = 1'b0;
        stat_clr_i  = 1'b0;
        par_rst_i   = 1'b0;
        cfg_en_i    = 1'b1;
        slotEn      = 1'b1;
        tick(300);
        checkOutput("drain_tx_dv", tx_dv_o, 1'b0);
        checkOutput("drain_usr_rdy", usr_rdy_o, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
